// File: rtl/tiny_rv_decode_q_if.sv
// Fetch-side and execute-side handshakes for the tiny_rv decode queue.
// master drives fetch offers and execute readiness; slave is the decode stage.
interface tiny_rv_decode_q_if #(
    parameter int PC_WIDTH = 32,
    parameter int CNT_W    = 2
);
    logic                fetch_valid;
    logic                fetch_ready;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [31:0]         fetch_inst;
    logic                decode_valid;
    logic                decode_ready;
    logic [PC_WIDTH-1:0] decode_pc;
    logic [31:0]         decode_inst;
    logic [31:0]         decode_imm32;
    logic [6:0]          decode_opcode;
    logic [2:0]          decode_funct3;
    logic [6:0]          decode_funct7;
    logic [4:0]          decode_rs1;
    logic [4:0]          decode_rs2;
    logic [4:0]          decode_rd;
    logic [2:0]          decode_fmt;
    logic                decode_illegal;
    logic [CNT_W-1:0]    decode_count;

    modport master (
        output fetch_valid, fetch_pc, fetch_inst, decode_ready,
        input  fetch_ready, decode_valid, decode_pc, decode_inst, decode_imm32,
               decode_opcode, decode_funct3, decode_funct7, decode_rs1,
               decode_rs2, decode_rd, decode_fmt, decode_illegal, decode_count
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_inst, decode_ready,
        output fetch_ready, decode_valid, decode_pc, decode_inst, decode_imm32,
               decode_opcode, decode_funct3, decode_funct7, decode_rs1,
               decode_rs2, decode_rd, decode_fmt, decode_illegal, decode_count
    );
endinterface

// File: rtl/tiny_rv_decode_q.sv
// RV32I decode stage: decodes the offered instruction combinationally and
// queues the result in a DEPTH-entry in-order FIFO toward execute.
module tiny_rv_decode_q #(
    parameter int DEPTH      = 2,
    parameter int PC_WIDTH   = 32,
    parameter bit EN_ILLEGAL = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    tiny_rv_decode_q_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_X = 3'd7;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         inst;
        logic [31:0]         imm;
        logic [2:0]          fmt;
        logic                ill;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           dec;
    entry_t           head;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, legal, valid;

    logic [31:0] in;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign in    = bus.fetch_inst;
    assign opc   = in[6:0];
    assign f3    = in[14:12];
    assign f7    = in[31:25];
    assign imm_i = {{20{in[31]}}, in[31:20]};
    assign imm_s = {{20{in[31]}}, in[31:25], in[11:7]};
    assign imm_b = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
    assign imm_u = {in[31:12], 12'b0};
    assign imm_j = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};

    always_comb begin
        dec      = '0;
        dec.pc   = bus.fetch_pc;
        dec.inst = in;
        dec.fmt  = FMT_X;
        legal    = 1'b1;
        case (opc)
            OPC_LOAD: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
                legal   = !(f3 inside {3'b011, 3'b110, 3'b111});
            end
            OPC_OPIMM: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
                legal   = !((f3 == 3'b001 && f7 != 7'b0) ||
                            (f3 == 3'b101 && !(f7 == 7'b0 || f7 == 7'b0100000)));
            end
            OPC_JALR: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
                legal   = (f3 == 3'b000);
            end
            OPC_SYSTEM, OPC_FENCE: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            OPC_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = imm_s;
                legal   = (f3 <= 3'b010);
            end
            OPC_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = imm_b;
                legal   = !(f3 inside {3'b010, 3'b011});
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = imm_j;
            end
            OPC_OP: begin
                dec.fmt = FMT_R;
                legal   = (f7 == 7'b0) ||
                          (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            // Unlisted opcodes, including any with inst[1:0] != 2'b11.
            default: legal = 1'b0;
        endcase
        dec.ill = EN_ILLEGAL && !legal;
    end

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full queue may still accept when execute drains the head this cycle.
    assign bus.fetch_ready = i_reset_n && !i_flush &&
                             ((count_q < CNT_W'(DEPTH)) || bus.decode_ready);
    assign valid = (count_q != '0);
    assign push  = bus.fetch_valid && bus.fetch_ready;
    assign pop   = valid && bus.decode_ready && !i_flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = wrap_inc(tail_q);
            if (pop)  head_d = wrap_inc(head_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[tail_q] <= dec;
    end

    assign head = valid ? mem_q[head_q] : '0;

    assign bus.decode_valid   = valid;
    assign bus.decode_pc      = head.pc;
    assign bus.decode_inst    = head.inst;
    assign bus.decode_imm32   = head.imm;
    assign bus.decode_opcode  = head.inst[6:0];
    assign bus.decode_funct3  = head.inst[14:12];
    assign bus.decode_funct7  = head.inst[31:25];
    assign bus.decode_rs1     = head.inst[19:15];
    assign bus.decode_rs2     = head.inst[24:20];
    assign bus.decode_rd      = head.inst[11:7];
    assign bus.decode_fmt     = head.fmt;
    assign bus.decode_illegal = head.ill;
    assign bus.decode_count   = count_q;
endmodule

// File: tb/tb_tiny_rv_decode_q.sv
// Bench for tiny_rv_decode_q: directed table, handshake corner sequences and
// random traffic against a queue-of-instructions reference model.
module tb_tiny_rv_decode_q;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, fv = 1'b0, dr = 1'b0;
    logic [31:0] pc = '0, inst = '0;

    always #5 clk = ~clk;

    tiny_rv_decode_q_if #(.PC_WIDTH(32), .CNT_W(CNT_W)) if0 ();
    tiny_rv_decode_q_if #(.PC_WIDTH(32), .CNT_W(CNT_W)) if1 ();

    assign if0.fetch_valid  = fv;
    assign if0.fetch_pc     = pc;
    assign if0.fetch_inst   = inst;
    assign if0.decode_ready = dr;
    assign if1.fetch_valid  = fv;
    assign if1.fetch_pc     = pc;
    assign if1.fetch_inst   = inst;
    assign if1.decode_ready = dr;

    tiny_rv_decode_q #(.DEPTH(DEPTH), .PC_WIDTH(32), .EN_ILLEGAL(1'b1)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .bus(if0.slave));
    tiny_rv_decode_q #(.DEPTH(DEPTH), .PC_WIDTH(32), .EN_ILLEGAL(1'b0)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .bus(if1.slave));

    typedef struct { logic [31:0] pc; logic [31:0] inst; } qent_t;
    typedef struct {
        logic [31:0] pc; logic [31:0] inst; logic [31:0] imm;
        logic [2:0] fmt; logic ill; logic [4:0] rd;
    } vec_t;

    qent_t mq[$];
    vec_t  tv[16];
    int    n_tests = 0, n_fail = 0;
    logic  m_push, m_pop;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode straight from the format/legality rules.
    function automatic void ref_dec(input logic [31:0] i, output logic [31:0] imm,
                                    output logic [2:0] fmt, output logic ill);
        logic signed [31:0] s, t;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        s  = $signed(i);
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        imm = 32'h0; fmt = 3'd7; ill = 1'b1;
        case (op)
            7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin fmt = 3'd1; imm = s >>> 20; end
            7'h23: begin t = s >>> 25; fmt = 3'd2; imm = (t << 5) | 32'(i[11:7]); end
            7'h63: begin
                t = s >>> 31; fmt = 3'd3;
                imm = (t << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h37, 7'h17: begin fmt = 3'd4; imm = i & 32'hFFFF_F000; end
            7'h6F: begin
                t = s >>> 31; fmt = 3'd5;
                imm = (t << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h33: fmt = 3'd0;
            default: ;
        endcase
        case (op)
            7'h33: ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            7'h13: ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
            7'h03: ill = (f3 == 3 || f3 == 6 || f3 == 7);
            7'h23: ill = (f3 > 2);
            7'h63: ill = (f3 == 2 || f3 == 3);
            7'h67: ill = (f3 != 0);
            7'h73, 7'h0F, 7'h37, 7'h17, 7'h6F: ill = 1'b0;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] in,
                         input logic r, input logic f);
        fv = v; pc = p; inst = in; dr = r; flush = f;
    endtask

    task automatic settle_check();
        logic        ev, rdy;
        logic [31:0] ep, ei, imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [67:0] e0, e1;
        #1;
        rdy = rst_n && !flush && (mq.size() < DEPTH || dr);
        ev  = (mq.size() != 0);
        ep = '0; ei = '0; imm = '0; fmt = '0; ill = 1'b0;
        if (ev) begin
            ep = mq[0].pc; ei = mq[0].inst;
            ref_dec(ei, imm, fmt, ill);
        end
        e0 = ev ? {imm, ei[6:0], ei[14:12], ei[31:25], ei[19:15], ei[24:20], ei[11:7], fmt, ill} : '0;
        e1 = ev ? {imm, ei[6:0], ei[14:12], ei[31:25], ei[19:15], ei[24:20], ei[11:7], fmt, 1'b0} : '0;
        chk("fetch_ready0", 128'(if0.fetch_ready), 128'(rdy));
        chk("fetch_ready1", 128'(if1.fetch_ready), 128'(rdy));
        chk("count0", 128'(if0.decode_count), 128'(mq.size()));
        chk("head0", {if0.decode_valid, if0.decode_pc, if0.decode_inst}, {ev, ep, ei});
        chk("fields0", {if0.decode_imm32, if0.decode_opcode, if0.decode_funct3, if0.decode_funct7,
                        if0.decode_rs1, if0.decode_rs2, if0.decode_rd, if0.decode_fmt,
                        if0.decode_illegal}, 128'(e0));
        chk("fields1", {if1.decode_valid, if1.decode_imm32, if1.decode_fmt, if1.decode_illegal,
                        if1.decode_pc}, {ev, e1[67:36], e1[3:0], ep});
        m_push = rdy && fv;
        m_pop  = ev && dr && !flush && rst_n;
    endtask

    task automatic clock();
        @(posedge clk);
        if (flush || !rst_n) mq.delete();
        else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back('{pc, inst});
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic v, input logic [31:0] p, input logic [31:0] in,
                       input logic r, input logic f);
        drive(v, p, in, r, f);
        settle_check();
        clock();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [11];
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        r = $urandom;
        if ($urandom_range(3, 0) != 0) r[6:0] = ops[$urandom_range(10, 0)];
        if ($urandom_range(1, 0) != 0) r[31:25] = ($urandom_range(1, 0) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    initial begin
        tv[0]  = '{32'h100, 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 5'd1};
        tv[1]  = '{32'h104, 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 5'd29};
        tv[2]  = '{32'h108, 32'h123452B7, 32'h12345000, 3'd4, 1'b0, 5'd5};
        tv[3]  = '{32'h10C, 32'h001000EF, 32'h00000800, 3'd5, 1'b0, 5'd1};
        tv[4]  = '{32'h110, 32'h00000000, 32'h00000000, 3'd7, 1'b1, 5'd0};
        tv[5]  = '{32'h114, 32'h40001033, 32'h00000000, 3'd0, 1'b1, 5'd0};
        tv[6]  = '{32'h118, 32'h00112623, 32'h0000000C, 3'd2, 1'b0, 5'd12};
        tv[7]  = '{32'h11C, 32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 5'd28};
        tv[8]  = '{32'h120, 32'h00000010, 32'h00000000, 3'd7, 1'b1, 5'd0};
        tv[9]  = '{32'h124, 32'h00003003, 32'h00000000, 3'd1, 1'b1, 5'd0};
        tv[10] = '{32'h128, 32'h40005013, 32'h00000400, 3'd1, 1'b0, 5'd0};
        tv[11] = '{32'h12C, 32'h40001013, 32'h00000400, 3'd1, 1'b1, 5'd0};
        tv[12] = '{32'h130, 32'h00001067, 32'h00000000, 3'd1, 1'b1, 5'd0};
        tv[13] = '{32'h134, 32'h00002063, 32'h00000000, 3'd3, 1'b1, 5'd0};
        tv[14] = '{32'h138, 32'h40000033, 32'h00000000, 3'd0, 1'b0, 5'd0};
        tv[15] = '{32'h13C, 32'h00001097, 32'h00001000, 3'd4, 1'b0, 5'd1};

        // Reset state, with an offer pending that must not be accepted.
        @(negedge clk);
        cyc(1'b1, 32'h40, 32'h00000013, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Directed decode table: push into empty queue, inspect head next cycle.
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, tv[k].pc, tv[k].inst, 1'b0, 1'b0);
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            settle_check();
            chk($sformatf("tv%0d", k),
                {if0.decode_valid, if0.decode_pc, if0.decode_imm32, if0.decode_fmt,
                 if0.decode_illegal, if0.decode_rd},
                {1'b1, tv[k].pc, tv[k].imm, tv[k].fmt, tv[k].ill, tv[k].rd});
            chk($sformatf("tv%0d_noill", k), 128'(if1.decode_illegal), 128'(0));
            clock();
        end

        // Backpressure: three offers with execute stalled, then push+pop at full.
        cyc(1'b1, 32'h200, 32'h00100093, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'h00200113, 1'b0, 1'b0);
        drive(1'b1, 32'h208, 32'h00300193, 1'b0, 1'b0);
        settle_check();
        chk("bp_full_ready", 128'(if0.fetch_ready), 128'(0));
        chk("bp_full_count", 128'(if0.decode_count), 128'(2));
        clock();
        drive(1'b1, 32'h208, 32'h00300193, 1'b1, 1'b0);
        settle_check();
        chk("bp_pushpop_ready", 128'(if0.fetch_ready), 128'(1));
        clock();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        settle_check();
        chk("bp_after_count", 128'(if0.decode_count), 128'(2));
        chk("bp_order1", 128'(if0.decode_pc), 128'(32'h204));
        clock();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        settle_check();
        chk("bp_order2", 128'(if0.decode_pc), 128'(32'h208));
        clock();
        cyc(1'b0, '0, '0, 1'b0, 1'b0);

        // Flush with a full queue and a concurrent offer.
        cyc(1'b1, 32'h300, 32'h00100093, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 32'h00200113, 1'b0, 1'b0);
        cyc(1'b1, 32'h308, 32'h00300193, 1'b1, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        settle_check();
        chk("flush_clear", {if0.decode_valid, if0.decode_count, if0.decode_pc, if0.decode_inst},
            {1'b0, 2'd0, 32'h0, 32'h0});

        // Async reset between edges with two entries queued.
        cyc(1'b1, 32'h400, 32'h00100093, 1'b0, 1'b0);
        cyc(1'b1, 32'h404, 32'h00200113, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        mq.delete();
        settle_check();
        chk("arst_zero", {if0.decode_valid, if0.decode_count, if0.decode_pc, if0.fetch_ready},
            {1'b0, 2'd0, 32'h0, 1'b0});
        clock();
        rst_n = 1'b1;
        cyc(1'b1, 32'h500, 32'h00500293, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        settle_check();
        chk("arst_first_push", {if0.decode_valid, if0.decode_pc}, {1'b1, 32'h500});
        clock();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++)
            cyc($urandom_range(3, 0) != 0, $urandom, rand_inst(),
                $urandom_range(2, 0) != 0, $urandom_range(19, 0) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tiny_rv_decode_q.md
# tiny_rv_decode_q

Parametrised RV32I decode stage with valid/ready handshakes on both sides and a DEPTH-entry decoded-instruction queue between fetch and execute. It fully decodes each accepted instruction: fields, sign-extended immediate for every base format, a format tag and an illegal-instruction flag. Entries are stored and presented in order. It replaces the stall/flush-driven single-register decode stage and sits between the fetch unit and the execute stage of the tiny_rv core.

## Interface
- DEPTH, 2, queue entries (≥1, any integer, not restricted to powers of two)
- PC_WIDTH, 32, PC field width
- EN_ILLEGAL, 1, 1 = illegal detection active; 0 = decode_illegal tied 0
- i_clk  in  1  clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_flush  in  1  synchronous flush, discards all entries
- fetch_valid  in  1  fetch offers an instruction
- fetch_ready  out  1  decode accepts this cycle
- fetch_pc  in  PC_WIDTH  PC of offered instruction
- fetch_inst  in  32  offered instruction
- decode_valid  out  1  head entry valid
- decode_ready  in  1  execute consumes head this cycle
- decode_pc  out  PC_WIDTH  head PC
- decode_inst  out  32  head raw instruction
- decode_imm32  out  32  head immediate
- decode_opcode  out  7, decode_funct3  out  3, decode_funct7  out  7  head fields
- decode_rs1 / decode_rs2 / decode_rd  out  5 each  head register indices
- decode_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=invalid
- decode_illegal  out  1  head is illegal
- decode_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Decode is combinational on fetch_inst; the result is written at the tail on accept (fetch_valid && fetch_ready).
- Pop occurs on decode_valid && decode_ready. Head and tail pointers wrap from DEPTH-1 to 0.
- fetch_ready = i_reset_n && !i_flush && (count < DEPTH || decode_ready). This is a combinational path from decode_ready. When full, push and pop in the same cycle are allowed and count is unchanged.
- decode_valid = (count != 0). All payload outputs read 0 while decode_valid=0.
- Immediates:
  - I (0000011, 0010011, 1100111, 1110011, 0001111): sext inst[31:20]
  - S (0100011): sext {inst[31:25], inst[11:7]}
  - B (1100011): sext {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U (0110111, 0010111): {inst[31:12], 12'b0}
  - J (1101111): sext {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R (0110011): 0
  - Any other opcode: fmt=7, imm=0.
- Illegal (EN_ILLEGAL=1) when any of the following holds:
  - inst[1:0] != 11, or the opcode is not listed above
  - OP: funct7 is not 0000000/0100000, or funct7=0100000 with funct3 not 000/101
  - OP-IMM: funct3=001 with funct7 != 0, or funct3=101 with funct7 not 0000000/0100000
  - LOAD: funct3 is 011, 110 or 111
  - STORE: funct3 > 010
  - BRANCH: funct3 is 010 or 011
  - JALR: funct3 != 000
- Illegal instructions are still queued and presented in order; the flag travels with the entry.

## Timing
- Reset (async, on i_reset_n low):
  - count, head and tail pointers = 0; all outputs 0; fetch_ready = 0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation drops all entries immediately. The first accept is possible in the first cycle with i_reset_n high.
- Latency: accept in cycle N -> visible at head in cycle N+1 when the queue is empty. There is no combinational bypass.
- Flush: i_flush high at edge N -> count=0 and decode_valid=0 after edge N. A push or pop in cycle N has no effect, and fetch_ready=0 in cycle N. Flush has priority over push and pop.
- Full (count=DEPTH): fetch_ready follows decode_ready.
- Empty: a pop cannot occur, because decode_valid=0.
- DEPTH=1: full throughput is sustained via simultaneous push and pop.
- decode_count is registered, and reflects the state after the last edge.

## Test plan
- Basic decode: 0xFFF00093 at pc 0x100, empty queue -> next cycle decode_valid=1, pc=0x100, imm=0xFFFFFFFF, rd=1, rs1=0, fmt=1, illegal=0.
- Immediate formats:
  - 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=3
  - 0x123452B7 (lui x5) -> imm=0x12345000, rd=5, fmt=4
  - jal x1,+2048 (0x001000EF) -> imm=0x00000800, fmt=5
- Backpressure (DEPTH=2): decode_ready=0, offer 3 instructions -> 2 accepted, fetch_ready=0, count=2. Then decode_ready=1 with fetch_valid=1 -> push and pop together, count stays 2, pop order matches push order with no loss or duplication.
- Flush: count=2 and i_flush=1 with fetch_valid=1 -> next cycle count=0, decode_valid=0, payload=0, offered instruction dropped.
- Illegal detection:
  - 0x00000000 -> illegal=1, fmt=7, imm=0
  - 0x40001033 (sll with funct7 0100000) -> illegal=1, fmt=0
  - Same stimulus with EN_ILLEGAL=0 -> illegal=0
- Async reset: drop i_reset_n between clock edges with count=2 -> outputs 0 immediately. Release, push 1 instruction -> valid on the following cycle.
